// File: rtl/mem_access_controller.sv
// MEM-stage data-memory access sequencer. It freezes the pipeline for a load/store in M,
// runs one req/ack transaction against a slow memory port, holds the load data, and then
// releases the pipeline for exactly one advance cycle.
module mem_access_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReqM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallMem,
  output logic                  FlushW,
  output logic                  MemErr
);

  localparam int unsigned CntWidth = $clog2(MAX_WAIT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: latch the access in IDLE, wait for ack or timeout in REQ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (MemReqM) begin
          we_d    = MemWriteM;
          addr_d  = ALUResultM;
          wdata_d = WriteDataM;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      // MemReqM still shows the finished instruction here, so it is not looked at.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: memory port from latched values, stall decoded from state and MemReqM.
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    ReadDataM = rdata_q;
    MemErr    = err_q;
    StallMem  = (state_q == StReq) || ((state_q == StIdle) && MemReqM);
    FlushW    = StallMem;
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: a table of accesses with a memory responder,
// a scoreboard queue of expected completions, and hand-written reset sequences.
module tb_mem_access_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemReqM, MemWriteM;
  logic [AW-1:0] ALUResultM;
  logic [DW-1:0] WriteDataM;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ReadDataM;
  logic          StallMem, FlushW, MemErr;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mem_access_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemReqM   (MemReqM),
    .MemWriteM (MemWriteM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ReadDataM (ReadDataM),
    .StallMem  (StallMem),
    .FlushW    (FlushW),
    .MemErr    (MemErr)
  );

  always #5 clk = ~clk;

  // ack_at: REQ cycle (1-based) on which ack is driven; 0 = never.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_at;
    logic [DW-1:0] rdata;
    bit            b2b;
    int            exp_stall;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_txn(input vec_t v);
    vec_t e;
    int   stall = 0;
    int   reqc  = 0;
    bit   done  = 0;
    exp_q.push_back(v);
    MemReqM    = 1'b1;
    MemWriteM  = v.we;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    for (int c = 0; c < 32 && !done; c++) begin
      #1;
      chk("flushw_eq_stall", 32'(FlushW), 32'(StallMem));
      if (StallMem) stall++;
      if (mem_req) begin
        reqc++;
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we", 32'(mem_we), 32'(v.we));
        chk("mem_wdata", mem_wdata, v.wdata);
        mem_ack   = (reqc == v.ack_at);
        mem_rdata = v.rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
      end
      if (!StallMem && stall > 0) begin
        done = 1;
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", 32'(stall), 32'(e.exp_stall));
          chk("req_cycles", 32'(reqc), 32'(e.exp_stall - 1));
          chk("ReadDataM", ReadDataM, e.exp_rd);
          chk("MemErr", 32'(MemErr), 32'(e.exp_err));
          chk("done_mem_req", 32'(mem_req), 32'd0);
        end
      end
      @(negedge clk);
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
    mem_ack = 1'b0;
    if (!v.b2b) begin
      MemReqM = 1'b0;
      #1;
      chk("idle_stall", 32'(StallMem), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_ReadDataM"}, ReadDataM, 32'd0);
    chk({tag, "_MemErr"}, 32'(MemErr), 32'd0);
    chk({tag, "_StallMem"}, 32'(StallMem), 32'd0);
    chk({tag, "_FlushW"}, 32'(FlushW), 32'd0);
  endtask

  initial begin
    //          we    addr         wdata         ack  rdata         b2b stall exp_rd        err
    vecs[0] = '{1'b0, 32'h100, 32'h0,        3, 32'hDEADBEEF, 0, 4, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h204, 32'h12345678, 1, 32'hBAD0BAD0, 0, 2, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h300, 32'h0,        2, 32'h11112222, 1, 3, 32'h11112222, 1'b0};
    vecs[3] = '{1'b0, 32'h304, 32'h0,        1, 32'h33334444, 0, 2, 32'h33334444, 1'b0};
    vecs[4] = '{1'b0, 32'h400, 32'h0,        4, 32'hCAFEF00D, 0, 5, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 32'h500, 32'h0,        0, 32'h77778888, 0, 5, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 32'h504, 32'h0,        2, 32'h5555AAAA, 0, 3, 32'h5555AAAA, 1'b1};
    vecs[7] = '{1'b1, 32'h508, 32'h9999CCCC, 3, 32'h0BADF00D, 0, 4, 32'h5555AAAA, 1'b1};

    rst        = 1'b1;
    MemReqM    = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a REQ wait, then a stray ack afterwards.
    MemReqM    = 1'b1;
    MemWriteM  = 1'b1;
    ALUResultM = 32'h600;
    WriteDataM = 32'hFEEDFACE;
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    mem_ack   = 1'b1;
    mem_rdata = 32'h13572468;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_rd", ReadDataM, 32'd0);
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    chk("stray_ack_stall", 32'(StallMem), 32'd0);
    @(negedge clk);
    #1;
    chk("stray_ack_req_late", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
